// File: rtl/vx_commit_arbiter_pkg.sv
// Shared commit-path types: the packed commit beat and the commit source indices.
// Also holds the modulo helper used by the round-robin picker.
package vx_commit_arbiter_pkg;

    localparam int NUM_COMMIT_SRCS  = 6;
    localparam int COMMIT_SRC_ALU   = 0;
    localparam int COMMIT_SRC_LD    = 1;
    localparam int COMMIT_SRC_ST    = 2;
    localparam int COMMIT_SRC_CSR   = 3;
    localparam int COMMIT_SRC_FPU   = 4;
    localparam int COMMIT_SRC_GPU   = 5;

    typedef struct packed {
        logic [4:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic        wb;
        logic [63:0] data;
    } commit_beat_t;

    localparam int COMMIT_BEAT_W = $bits(commit_beat_t);

    function automatic int rr_offset(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Round-robin picker: first valid index after rr_ptr, as one-hot grant plus index.
// Purely combinational, no backpressure of its own.
module vx_rr_pick
    import vx_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 6,
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [IDXW-1:0]     rr_ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDXW-1:0]     grant_idx
);

    int   scan_idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        // Scan starts one past the last winner so the last winner is checked last.
        for (int k = 1; k <= NUM_REQS; k++) begin
            scan_idx = rr_offset(int'(rr_ptr), k, NUM_REQS);
            if (!found && valid[IDXW'(scan_idx)]) begin
                found                    = 1'b1;
                grant[IDXW'(scan_idx)]   = 1'b1;
                grant_idx                = IDXW'(scan_idx);
            end
        end
    end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Writeback port arbiter: round-robin with per-source packet lock; 1-cycle registered output.
// Backpressure: req_ready only when the output register can load; wb_ready=0 with wb_valid holds all sources.
module vx_commit_arbiter
    import vx_commit_arbiter_pkg::*;
#(
    parameter int  NUM_REQS      = NUM_COMMIT_SRCS,
    parameter int  DATAW         = COMMIT_BEAT_W,
    parameter int  PERF_CTR_BITS = 44,
    localparam int IDXW          = $clog2(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]            req_eop,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           wb_valid,
    output logic [DATAW-1:0]               wb_data,
    output logic                           wb_eop,
    output logic [IDXW-1:0]                wb_sel,
    input  logic                           wb_ready,
    output logic [PERF_CTR_BITS-1:0]       perf_conflicts,
    output logic                           busy
);

    logic [IDXW-1:0]     rr_ptr;
    logic [IDXW-1:0]     lock_idx;
    logic                lock_active;
    logic [NUM_REQS-1:0] rr_grant;
    logic [IDXW-1:0]     rr_idx;
    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     grant_idx;
    logic                can_load;
    logic                xfer;

    vx_rr_pick #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // A held lock starves everyone else, even if the locked source is idle.
    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
        if (lock_active) begin
            grant           = '0;
            grant[lock_idx] = req_valid[lock_idx];
            grant_idx       = lock_idx;
        end
    end

    assign can_load  = ~wb_valid | wb_ready;
    assign xfer      = can_load & (|(req_valid & grant));
    assign req_ready = reset_n ? (grant & {NUM_REQS{can_load}}) : '0;
    assign busy      = wb_valid | lock_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= IDXW'(NUM_REQS - 1);
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (xfer) begin
            rr_ptr      <= grant_idx;
            lock_active <= ~req_eop[grant_idx];
            if (!req_eop[grant_idx]) begin
                lock_idx <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
            wb_sel   <= '0;
        end else begin
            if (can_load) begin
                wb_valid <= |(req_valid & grant);
            end
            if (xfer) begin
                wb_data <= req_data[grant_idx];
                wb_eop  <= req_eop[grant_idx];
                wb_sel  <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflicts <= '0;
        end else if ($countones(req_valid) >= 2) begin
            perf_conflicts <= perf_conflicts + PERF_CTR_BITS'(1);
        end
    end

endmodule
